// File: rtl/isa_pkg.sv
// Shared ISA definitions: opcodes, ALU operations, status codes, X/M latch layout.
package isa_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned REGW = 5;

  // Major opcodes (insn[31:27])
  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_J     = 5'b00001;
  localparam logic [4:0] OP_BNE   = 5'b00010;
  localparam logic [4:0] OP_JAL   = 5'b00011;
  localparam logic [4:0] OP_JR    = 5'b00100;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_BLT   = 5'b00110;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_SETX  = 5'b10101;
  localparam logic [4:0] OP_BEX   = 5'b10110;

  // ALU operation codes
  localparam logic [4:0] ALU_ADD = 5'd0;
  localparam logic [4:0] ALU_SUB = 5'd1;
  localparam logic [4:0] ALU_AND = 5'd2;
  localparam logic [4:0] ALU_OR  = 5'd3;
  localparam logic [4:0] ALU_SLL = 5'd4;
  localparam logic [4:0] ALU_SRA = 5'd5;

  // Values written to the status register on overflow
  localparam logic [31:0] RSTATUS_ADD  = 32'd1;
  localparam logic [31:0] RSTATUS_ADDI = 32'd2;
  localparam logic [31:0] RSTATUS_SUB  = 32'd3;

  localparam logic [4:0] REG_ZERO   = 5'd0;
  localparam logic [4:0] REG_STATUS = 5'd30;
  localparam logic [4:0] REG_RA     = 5'd31;

  // Contents of the X/M pipeline latch
  typedef struct packed {
    logic        valid;
    logic [31:0] insn;
    logic [31:0] o;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        we;
  } xm_t;

  // Sign-extend the 17-bit immediate field
  function automatic logic [31:0] sext_imm(input logic [31:0] insn);
    return {{15{insn[16]}}, insn[16:0]};
  endfunction

  // Zero-extend the 27-bit jump target field
  function automatic logic [31:0] zext_target(input logic [31:0] insn);
    return {5'b00000, insn[26:0]};
  endfunction

endpackage

// File: rtl/alu.sv
// Shared 32-bit ALU: add/sub/and/or/shifts plus compare flags and overflow.
module alu
  import isa_pkg::*;
(
  input  logic [31:0] data_operand_a_i,
  input  logic [31:0] data_operand_b_i,
  input  logic [4:0]  ctrl_aluop_i,
  input  logic [4:0]  ctrl_shamt_i,
  output logic [31:0] data_result_o,
  output logic        is_not_equal_o,
  output logic        is_less_than_o,
  output logic        overflow_o
);

  logic [31:0] sum_s;
  logic [31:0] diff_s;
  logic        add_ovf_s;
  logic        sub_ovf_s;

  assign sum_s     = data_operand_a_i + data_operand_b_i;
  assign diff_s    = data_operand_a_i - data_operand_b_i;
  assign add_ovf_s = (data_operand_a_i[31] == data_operand_b_i[31]) && (sum_s[31] != data_operand_a_i[31]);
  assign sub_ovf_s = (data_operand_a_i[31] != data_operand_b_i[31]) && (diff_s[31] != data_operand_a_i[31]);

  assign is_not_equal_o = (data_operand_a_i != data_operand_b_i);
  // Sign of the true difference: corrected by the overflow flag
  assign is_less_than_o = diff_s[31] ^ sub_ovf_s;

  // Result and overflow selection by operation
  always_comb begin
    data_result_o = sum_s;
    overflow_o    = 1'b0;
    case (ctrl_aluop_i)
      ALU_ADD: begin data_result_o = sum_s;  overflow_o = add_ovf_s; end
      ALU_SUB: begin data_result_o = diff_s; overflow_o = sub_ovf_s; end
      ALU_AND: data_result_o = data_operand_a_i & data_operand_b_i;
      ALU_OR:  data_result_o = data_operand_a_i | data_operand_b_i;
      ALU_SLL: data_result_o = data_operand_a_i << ctrl_shamt_i;
      ALU_SRA: data_result_o = $unsigned($signed(data_operand_a_i) >>> ctrl_shamt_i);
      default: data_result_o = sum_s;
    endcase
  end

endmodule

// File: rtl/execute_stage_bypass_mux.sv
// Operand bypass: X/M result beats M/W writeback; register 0 is never bypassed.
module bypass_mux
  import isa_pkg::*;
(
  input  logic [4:0]  idx_i,
  input  logic [31:0] latch_val_i,
  input  logic        xm_we_i,
  input  logic [4:0]  xm_rd_i,
  input  logic [31:0] xm_o_i,
  input  logic        mw_we_i,
  input  logic [4:0]  mw_rd_i,
  input  logic [31:0] mw_data_i,
  output logic [31:0] val_o
);

  // Priority select of the freshest value for this register index
  always_comb begin
    if (idx_i == REG_ZERO) begin
      val_o = latch_val_i;
    end else if (xm_we_i && (xm_rd_i == idx_i)) begin
      val_o = xm_o_i;
    end else if (mw_we_i && (mw_rd_i == idx_i)) begin
      val_o = mw_data_i;
    end else begin
      val_o = latch_val_i;
    end
  end

endmodule

// File: rtl/execute_stage.sv
// Execute stage: bypassing, ALU, branch resolution, writeback overrides, X/M latch.
module execute_stage
  import isa_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        dx_valid,
  input  logic [31:0] dx_pc,
  input  logic [31:0] dx_insn,
  input  logic [31:0] dx_a,
  input  logic [31:0] dx_b,
  input  logic        mw_we,
  input  logic [4:0]  mw_rd,
  input  logic [31:0] mw_data,
  output logic        xm_valid,
  output logic [31:0] xm_insn,
  output logic [31:0] xm_o,
  output logic [31:0] xm_b,
  output logic [4:0]  xm_rd,
  output logic        xm_we,
  output logic        br_taken,
  output logic [31:0] br_target
);

  xm_t xm_q;
  xm_t xm_d;

  logic [4:0]  opcode, rd_f, rs_f, rt_f, shamt_f, aluop_f;
  logic [31:0] imm, target;
  logic [4:0]  idx_a, idx_b;
  logic [31:0] a_byp, b_byp;
  logic [31:0] alu_b;
  logic [4:0]  alu_op;
  logic [31:0] alu_res;
  logic        alu_ne, alu_lt, alu_ovf;
  logic        is_rtype, uses_imm, is_cmp_branch;
  logic        taken_raw;
  logic [31:0] pc_plus1;

  assign opcode  = dx_insn[31:27];
  assign rd_f    = dx_insn[26:22];
  assign rs_f    = dx_insn[21:17];
  assign rt_f    = dx_insn[16:12];
  assign shamt_f = dx_insn[11:7];
  assign aluop_f = dx_insn[6:2];
  assign imm     = sext_imm(dx_insn);
  assign target  = zext_target(dx_insn);
  assign pc_plus1 = dx_pc + 32'd1;

  assign is_rtype      = (opcode == OP_RTYPE);
  assign uses_imm      = (opcode == OP_ADDI) || (opcode == OP_LW) || (opcode == OP_SW);
  assign is_cmp_branch = (opcode == OP_BNE) || (opcode == OP_BLT);

  // Register indices feeding the bypass network for each instruction class
  always_comb begin
    idx_a = rs_f;
    idx_b = rt_f;
    case (opcode)
      OP_ADDI, OP_LW, OP_SW: begin idx_a = rs_f; idx_b = rd_f; end
      OP_BNE, OP_BLT:        begin idx_a = rd_f; idx_b = rs_f; end
      OP_JR:                 idx_b = rd_f;
      OP_BEX:                idx_a = REG_STATUS;
      default:               begin idx_a = rs_f; idx_b = rt_f; end
    endcase
  end

  bypass_mux u_byp_a (
    .idx_i(idx_a), .latch_val_i(dx_a),
    .xm_we_i(xm_q.we), .xm_rd_i(xm_q.rd), .xm_o_i(xm_q.o),
    .mw_we_i(mw_we), .mw_rd_i(mw_rd), .mw_data_i(mw_data),
    .val_o(a_byp)
  );

  bypass_mux u_byp_b (
    .idx_i(idx_b), .latch_val_i(dx_b),
    .xm_we_i(xm_q.we), .xm_rd_i(xm_q.rd), .xm_o_i(xm_q.o),
    .mw_we_i(mw_we), .mw_rd_i(mw_rd), .mw_data_i(mw_data),
    .val_o(b_byp)
  );

  assign alu_b  = uses_imm ? imm : b_byp;
  assign alu_op = is_rtype ? aluop_f : (is_cmp_branch ? ALU_SUB : ALU_ADD);

  alu u_alu (
    .data_operand_a_i(a_byp),
    .data_operand_b_i(alu_b),
    .ctrl_aluop_i(alu_op),
    .ctrl_shamt_i(shamt_f),
    .data_result_o(alu_res),
    .is_not_equal_o(alu_ne),
    .is_less_than_o(alu_lt),
    .overflow_o(alu_ovf)
  );

  // Next X/M contents: write enable, destination and result with overrides
  always_comb begin
    xm_d       = '0;
    xm_d.valid = 1'b1;
    xm_d.insn  = dx_insn;
    xm_d.b     = b_byp;
    xm_d.o     = alu_res;
    xm_d.rd    = rd_f;
    xm_d.we    = 1'b0;
    case (opcode)
      OP_RTYPE, OP_ADDI, OP_LW: xm_d.we = 1'b1;
      OP_SETX: begin xm_d.we = 1'b1; xm_d.rd = REG_STATUS; xm_d.o = target; end
      OP_JAL:  begin xm_d.we = 1'b1; xm_d.rd = REG_RA;     xm_d.o = pc_plus1; end
      default: xm_d.we = 1'b0;
    endcase
    if (alu_ovf && is_rtype && (aluop_f == ALU_ADD)) begin
      xm_d.we = 1'b1; xm_d.rd = REG_STATUS; xm_d.o = RSTATUS_ADD;
    end else if (alu_ovf && (opcode == OP_ADDI)) begin
      xm_d.we = 1'b1; xm_d.rd = REG_STATUS; xm_d.o = RSTATUS_ADDI;
    end else if (alu_ovf && is_rtype && (aluop_f == ALU_SUB)) begin
      xm_d.we = 1'b1; xm_d.rd = REG_STATUS; xm_d.o = RSTATUS_SUB;
    end else begin
      xm_d.we = xm_d.we;
    end
    // Non-writing instructions carry no destination
    if (!xm_d.we) begin
      xm_d.rd = REG_ZERO;
    end else begin
      xm_d.rd = xm_d.rd;
    end
  end

  // Branch/jump condition and redirect target
  always_comb begin
    taken_raw = 1'b0;
    br_target = pc_plus1 + imm;
    case (opcode)
      OP_BNE:       begin taken_raw = alu_ne;            br_target = pc_plus1 + imm; end
      OP_BLT:       begin taken_raw = !alu_lt && alu_ne; br_target = pc_plus1 + imm; end
      OP_J, OP_JAL: begin taken_raw = 1'b1;              br_target = target; end
      OP_JR:        begin taken_raw = 1'b1;              br_target = b_byp; end
      OP_BEX:       begin taken_raw = (a_byp != 32'd0);  br_target = target; end
      default:      taken_raw = 1'b0;
    endcase
  end

  assign br_taken = taken_raw && dx_valid && !stall && !reset;

  // X/M latch: reset beats stall; stall holds; a bubble clears the slot
  always_ff @(posedge clock) begin
    if (reset) begin
      xm_q <= '0;
    end else if (stall) begin
      xm_q <= xm_q;
    end else if (!dx_valid) begin
      xm_q <= '0;
    end else begin
      xm_q <= xm_d;
    end
  end

  assign xm_valid = xm_q.valid;
  assign xm_insn  = xm_q.insn;
  assign xm_o     = xm_q.o;
  assign xm_b     = xm_q.b;
  assign xm_rd    = xm_q.rd;
  assign xm_we    = xm_q.we;

endmodule

// File: tb/tb_execute_stage.sv
// Directed scoreboard bench for execute_stage.
module tb_execute_stage;

  logic        clock;
  logic        reset;
  logic        stall;
  logic        dx_valid;
  logic [31:0] dx_pc, dx_insn, dx_a, dx_b;
  logic        mw_we;
  logic [4:0]  mw_rd;
  logic [31:0] mw_data;
  logic        xm_valid;
  logic [31:0] xm_insn, xm_o, xm_b;
  logic [4:0]  xm_rd;
  logic        xm_we;
  logic        br_taken;
  logic [31:0] br_target;

  typedef struct {
    logic        v;
    logic [31:0] insn;
    logic [31:0] o;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        we;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  execute_stage dut (
    .clock(clock), .reset(reset), .stall(stall),
    .dx_valid(dx_valid), .dx_pc(dx_pc), .dx_insn(dx_insn),
    .dx_a(dx_a), .dx_b(dx_b),
    .mw_we(mw_we), .mw_rd(mw_rd), .mw_data(mw_data),
    .xm_valid(xm_valid), .xm_insn(xm_insn), .xm_o(xm_o), .xm_b(xm_b),
    .xm_rd(xm_rd), .xm_we(xm_we),
    .br_taken(br_taken), .br_target(br_target)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [31:0] enc_r(input logic [4:0] rd, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] aluop);
    return {5'b00000, rd, rs, rt, 5'b00000, aluop, 2'b00};
  endfunction

  function automatic logic [31:0] enc_i(input logic [4:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs, input logic [16:0] imm);
    return {op, rd, rs, imm};
  endfunction

  function automatic logic [31:0] enc_j(input logic [4:0] op, input logic [26:0] t);
    return {op, t};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] insn,
                       input logic [31:0] a, input logic [31:0] b);
    dx_valid = v; dx_pc = pc; dx_insn = insn; dx_a = a; dx_b = b;
    #1;
  endtask

  task automatic set_mw(input logic we, input logic [4:0] rd, input logic [31:0] d);
    mw_we = we; mw_rd = rd; mw_data = d;
  endtask

  task automatic expect_xm(input logic v, input logic [31:0] insn, input logic [31:0] o,
                           input logic [31:0] b, input logic [4:0] rd, input logic we);
    exp_t e;
    e.v = v; e.insn = insn; e.o = o; e.b = b; e.rd = rd; e.we = we;
    exp_q.push_back(e);
  endtask

  task automatic step();
    exp_t e;
    @(posedge clock);
    #1;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL scoreboard_empty observed=%0d expected=1", exp_q.size());
    end else begin
      e = exp_q.pop_front();
      chk("xm_valid", {31'd0, xm_valid}, {31'd0, e.v});
      chk("xm_insn",  xm_insn, e.insn);
      chk("xm_o",     xm_o, e.o);
      chk("xm_b",     xm_b, e.b);
      chk("xm_rd",    {27'd0, xm_rd}, {27'd0, e.rd});
      chk("xm_we",    {31'd0, xm_we}, {31'd0, e.we});
    end
  endtask

  initial begin
    logic [31:0] insn;
    reset = 1'b1; stall = 1'b0;
    set_mw(1'b0, 5'd0, 32'd0);

    // Reset held with a valid instruction
    drive(1'b1, 32'd0, enc_r(5'd3, 5'd1, 5'd2, 5'd0), 32'd5, 32'd6);
    chk("rst_br_taken", {31'd0, br_taken}, 32'd0);
    expect_xm(1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0);
    step();
    reset = 1'b0;

    // add overflow
    insn = enc_r(5'd3, 5'd1, 5'd2, 5'd0);
    drive(1'b1, 32'd1, insn, 32'h7FFFFFFF, 32'd1);
    expect_xm(1'b1, insn, 32'd1, 32'd1, 5'd30, 1'b1);
    step();

    // sub overflow
    insn = enc_r(5'd3, 5'd1, 5'd2, 5'd1);
    drive(1'b1, 32'd2, insn, 32'h80000000, 32'd1);
    expect_xm(1'b1, insn, 32'd3, 32'd1, 5'd30, 1'b1);
    step();

    // addi overflow
    insn = enc_i(5'b00101, 5'd1, 5'd2, 17'd1);
    drive(1'b1, 32'd3, insn, 32'h7FFFFFFF, 32'h000000AA);
    expect_xm(1'b1, insn, 32'd2, 32'h000000AA, 5'd30, 1'b1);
    step();

    // addi r1,r0,5
    insn = enc_i(5'b00101, 5'd1, 5'd0, 17'd5);
    drive(1'b1, 32'd4, insn, 32'd0, 32'd0);
    expect_xm(1'b1, insn, 32'd5, 32'd0, 5'd1, 1'b1);
    step();

    // add r2,r1,r0: X/M (5) beats M/W (9); B index 0 uses latch
    set_mw(1'b1, 5'd1, 32'd9);
    insn = enc_r(5'd2, 5'd1, 5'd0, 5'd0);
    drive(1'b1, 32'd5, insn, 32'd100, 32'h20);
    expect_xm(1'b1, insn, 32'h25, 32'h20, 5'd2, 1'b1);
    step();

    // rs=0 with mw_rd=0: latch values are used
    set_mw(1'b1, 5'd0, 32'd9);
    insn = enc_r(5'd2, 5'd0, 5'd3, 5'd0);
    drive(1'b1, 32'd6, insn, 32'h11, 32'h22);
    expect_xm(1'b1, insn, 32'h33, 32'h22, 5'd2, 1'b1);
    step();

    // M/W-only bypass on A
    set_mw(1'b1, 5'd5, 32'h1000);
    insn = enc_r(5'd4, 5'd5, 5'd6, 5'd0);
    drive(1'b1, 32'd7, insn, 32'd1, 32'd2);
    expect_xm(1'b1, insn, 32'h1002, 32'd2, 5'd4, 1'b1);
    step();

    // bne rd=4 (bypassed 0x1002) vs rs=7 (3), imm=-2, pc=10
    set_mw(1'b0, 5'd0, 32'd0);
    insn = enc_i(5'b00010, 5'd4, 5'd7, 17'h1FFFE);
    drive(1'b1, 32'd10, insn, 32'd0, 32'd3);
    chk("bne_taken", {31'd0, br_taken}, 32'd1);
    chk("bne_target", br_target, 32'd9);
    expect_xm(1'b1, insn, 32'h00000FFF, 32'd3, 5'd0, 1'b0);
    step();

    // blt with rd value 3, rs value 5: rs<rd false -> not taken
    insn = enc_i(5'b00110, 5'd7, 5'd4, 17'd5);
    drive(1'b1, 32'd30, insn, 32'd3, 32'd5);
    chk("blt_nt_taken", {31'd0, br_taken}, 32'd0);
    expect_xm(1'b1, insn, 32'hFFFFFFFE, 32'd5, 5'd0, 1'b0);
    step();

    // blt with rd value 7, rs value 4: taken to pc+1+5
    drive(1'b1, 32'd30, insn, 32'd7, 32'd4);
    chk("blt_t_taken", {31'd0, br_taken}, 32'd1);
    chk("blt_t_target", br_target, 32'd36);
    expect_xm(1'b1, insn, 32'd3, 32'd4, 5'd0, 1'b0);
    step();

    // jal 0x100 at pc=20
    insn = enc_j(5'b00011, 27'h100);
    drive(1'b1, 32'd20, insn, 32'd0, 32'd0);
    chk("jal_taken", {31'd0, br_taken}, 32'd1);
    chk("jal_target", br_target, 32'h100);
    expect_xm(1'b1, insn, 32'd21, 32'd0, 5'd31, 1'b1);
    step();

    // Stall with j 0x200: no redirect, X/M holds the jal
    stall = 1'b1;
    drive(1'b1, 32'd40, enc_j(5'b00001, 27'h200), 32'd0, 32'd0);
    chk("stall_br_taken", {31'd0, br_taken}, 32'd0);
    expect_xm(1'b1, insn, 32'd21, 32'd0, 5'd31, 1'b1);
    step();

    // Stall released: j re-evaluates
    stall = 1'b0;
    insn = enc_j(5'b00001, 27'h200);
    drive(1'b1, 32'd40, insn, 32'd0, 32'd0);
    chk("j_taken", {31'd0, br_taken}, 32'd1);
    chk("j_target", br_target, 32'h200);
    expect_xm(1'b1, insn, 32'd0, 32'd0, 5'd0, 1'b0);
    step();

    // bex with r30=0: not taken
    insn = enc_j(5'b10110, 27'h300);
    drive(1'b1, 32'd41, insn, 32'd0, 32'd0);
    chk("bex0_taken", {31'd0, br_taken}, 32'd0);
    expect_xm(1'b1, insn, 32'd0, 32'd0, 5'd0, 1'b0);
    step();

    // setx 3
    insn = enc_j(5'b10101, 27'd3);
    drive(1'b1, 32'd42, insn, 32'd0, 32'd0);
    expect_xm(1'b1, insn, 32'd3, 32'd0, 5'd30, 1'b1);
    step();

    // bex sees bypassed r30=3: taken
    insn = enc_j(5'b10110, 27'h400);
    drive(1'b1, 32'd43, insn, 32'd0, 32'd0);
    chk("bex1_taken", {31'd0, br_taken}, 32'd1);
    chk("bex1_target", br_target, 32'h400);
    expect_xm(1'b1, insn, 32'd3, 32'd0, 5'd0, 1'b0);
    step();

    // Bubble
    drive(1'b0, 32'd44, enc_j(5'b00001, 27'h10), 32'd1, 32'd2);
    chk("bubble_br_taken", {31'd0, br_taken}, 32'd0);
    expect_xm(1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0);
    step();

    // sw r5, 4(r2): address and store data
    insn = enc_i(5'b00111, 5'd5, 5'd2, 17'd4);
    drive(1'b1, 32'd45, insn, 32'h100, 32'hBEEF);
    expect_xm(1'b1, insn, 32'h104, 32'hBEEF, 5'd0, 1'b0);
    step();

    // Reset together with stall: reset wins
    reset = 1'b1; stall = 1'b1;
    drive(1'b1, 32'd46, enc_r(5'd3, 5'd1, 5'd2, 5'd0), 32'd1, 32'd1);
    expect_xm(1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
# execute_stage

Execute (X) stage of the five-stage pipeline. Takes the decoded instruction and register operands from the D/X latch, resolves bypassing, drives the shared ALU, and evaluates branches/jumps. Applies overflow-exception and `setx`/`jal` writeback overrides, then registers the result into the X/M latch consumed by the memory stage.

## Interface
- No parameters. Data width is 32 bits, register index width is 5 bits.
- `clock`  in  1  the only clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high; clears every X/M register.
- `stall`  in  1  hold the X/M latch and suppress the redirect.
- `dx_valid`  in  1  D/X holds a real instruction; 0 means bubble.
- `dx_pc`  in  32  PC of the instruction.
- `dx_insn`  in  32  instruction word.
- `dx_a`  in  32  register-file value for A index.
- `dx_b`  in  32  register-file value for B index.
- `mw_we`  in  1  M/W write enable (bypass source).
- `mw_rd`  in  5  M/W destination register.
- `mw_data`  in  32  M/W writeback value.
- `xm_valid`  out  1  X/M holds a real instruction.
- `xm_insn`  out  32  registered instruction word.
- `xm_o`  out  32  registered result or address.
- `xm_b`  out  32  registered bypassed B operand (store data).
- `xm_rd`  out  5  registered destination index.
- `xm_we`  out  1  registered register-write enable.
- `br_taken`  out  1  combinational redirect request.
- `br_target`  out  32  combinational redirect PC.

## Operation
Instruction fields: opcode [31:27], rd [26:22], rs [21:17], rt [16:12], shamt [11:7], aluop [6:2], imm [16:0] (sign-extended), target [26:0] (zero-extended).

Operand indices:
- R-type (00000): A=rs, B=rt.
- addi/lw/sw: A=rs, B=rd. The ALU B input is imm; `xm_b` carries bypassed rd.
- bne/blt: A=rd, B=rs.
- jr: B=rd.
- bex: A=30.

Bypass, per operand, in priority order:
- Index 0 always selects the latch value.
- `xm_we && xm_rd==idx` selects `xm_o`.
- Otherwise `mw_we && mw_rd==idx` selects `mw_data`.
- Otherwise the `dx_*` value.

ALU opcode is aluop for R-type, otherwise 00000 (add). Branch compares use 00001.

Writeback overrides:
- Add overflow: rd=30, result=1.
- addi overflow: rd=30, result=2.
- Sub overflow: rd=30, result=3.
- setx: rd=30, result=target.
- jal: rd=31, result=dx_pc+1.
- `xm_we` is 1 for R-type, addi, lw, setx, jal; 0 for all others. An overflow forces `xm_we`=1.

Branch resolution, with `br_taken` gated by `dx_valid && !stall`:
- bne: taken when isNotEqual.
- blt: taken when `!isLessThan && isNotEqual`, i.e. rs<rd with A=rd, B=rs.
- j/jal: always taken.
- jr: always taken.
- bex: taken when A≠0.
- Targets: branches go to dx_pc+1+imm; j/jal/bex go to target; jr goes to bypassed B.

## Timing
- Reset: all `xm_*` registers go to 0. `br_taken`=0 while `dx_valid`=0.
- Latency: one cycle from D/X to X/M. `br_taken` and `br_target` are valid in the same cycle as D/X.
- `stall`=1: X/M holds, `br_taken`=0, and the instruction re-evaluates in the next cycle.
- Bubble (`dx_valid`=0, no stall): `xm_valid`=0, `xm_we`=0, `xm_rd`=0.
- Simultaneous X/M and M/W hits on the same index: X/M wins.
- Reset asserted together with `stall`: reset wins.
- PC arithmetic wraps modulo 2^32.

## Structure
- Shared package `isa_pkg` holds:
  - opcode constants;
  - ALU opcodes (ADD=0, SUB=1, AND=2, OR=3, SLL=4, SRA=5);
  - rstatus codes (1 add, 2 addi, 3 sub);
  - register indices `REG_STATUS`=30, `REG_RA`=31.
- The block instantiates the existing ALU and one sub-module, `bypass_mux`, twice (operands A and B).

## Test plan
1. Reset held with `dx_valid`=1 → all `xm_*`=0 and `br_taken`=0.
2. add r3,r1,r2 with 0x7FFFFFFF+1 → `xm_rd`=30, `xm_o`=1, `xm_we`=1; sub 0x80000000−1 → `xm_o`=3.
3. Back-to-back add r1 (X/M `xm_o`=5) while M/W also writes r1=9, then add r2,r1,r0 → A=5; with rs=0 and `mw_rd`=0 → A=`dx_a`.
4. bne with rd=4, rs=7, imm=−2, pc=10 → `br_taken`=1, `br_target`=9; blt with rd=7, rs=4 → `br_taken`=0.
5. jal target=0x100 at pc=20 → `br_target`=0x100, `xm_rd`=31, `xm_o`=21; `stall`=1 → `br_taken`=0 and X/M unchanged.
6. bex with r30=0 → not taken; setx 3 then bex → `xm_o`=3 bypassed, `br_taken`=1.
